// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the sum UART transmitter.
// The frame is one start bit, DATA_BITS data bits, an optional parity bit, and one stop bit.
package sum_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic int frame_bits(input bit parity_en);
    return parity_en ? DATA_BITS + 3 : DATA_BITS + 2;
  endfunction

endpackage

// File: rtl/sum_uart_baud_cnt.sv
// Bit-period timer. It raises tick on the last cycle of each CLKS_PER_BIT window.
// It stays at zero while run is low.
module sum_uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sum_uart_tx.sv
// Takes adder sums over valid/ready and sends each one as an LSB-first UART frame.
// An even-parity bit can be added to each frame.
module sum_uart_tx
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sum_i,
  input  logic       sum_valid_i,
  output logic       sum_ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state, state_next;
  logic [7:0] shreg, shreg_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic       parity, parity_next;
  logic       tx_next, busy_next, done_next;
  logic       tick;
  logic       xfer;

  // Ready depends only on registered state, so valid never loops back into ready.
  assign sum_ready_o = (state == IDLE);
  assign xfer        = sum_valid_i && sum_ready_o;

  sum_uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state != IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so a missed branch cannot infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (xfer) state_next = START;
      START:   if (tick) state_next = DATA;
      DATA:    if (tick && bit_cnt == LAST_BIT) state_next = PARITY_EN ? PARITY : STOP;
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The shift register, bit counter and parity are loaded on the transfer edge.
  // After that they only change on bit boundaries inside DATA.
  always_comb begin
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    parity_next  = parity;
    if (xfer) begin
      shreg_next  = sum_i;
      parity_next = ^sum_i;
    end else if (state == DATA && tick) begin
      shreg_next   = shreg >> 1;
      bit_cnt_next = bit_cnt + 1'b1;
    end
  end

  // NOTE: the datapath registers are reset along with the control state, so nothing is X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      parity  <= 1'b0;
    end else begin
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      parity  <= parity_next;
    end
  end

  // The outputs are computed from the next state, so the registered pins line up with the state register.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    done_next = (state == STOP) && tick;
    unique case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      PARITY:  tx_next = parity_next;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_o   <= 1'b1;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      tx_o   <= tx_next;
      busy_o <= busy_next;
      done_o <= done_next;
    end
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx. Two instances are used: one without parity and one with parity.
// Each output is checked every cycle against the bit sequence the frame rules give.
module tb_sum_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sum_a, sum_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .sum_i(sum_a), .sum_valid_i(valid_a),
    .sum_ready_o(ready_a), .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a)
  );

  sum_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .sum_i(sum_b), .sum_valid_i(valid_b),
    .sum_ready_o(ready_b), .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b)
  );

  // Observed outputs packed as {tx, ready, busy, done}.
  function automatic logic [3:0] obs(input bit sel);
    return sel ? {tx_b, ready_b, busy_b, done_b} : {tx_a, ready_a, busy_a, done_a};
  endfunction

  // Line level for frame bit idx: start, data LSB first, optional even parity, stop.
  function automatic logic exp_bit(input logic [7:0] d, input bit par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (par && idx == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [3:0] o, input logic [3:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic drive(input bit sel, input logic [7:0] d, input logic v);
    if (sel) begin sum_b = d; valid_b = v; end
    else     begin sum_a = d; valid_a = v; end
  endtask

  task automatic idle_check(input bit sel, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s_idle%0d", tag, i), obs(sel), 4'b1100);
    end
  endtask

  // Call this at a negedge while the DUT is idle. It drives byte d and checks every cycle of the frame.
  // Right after the capture, sum_i becomes next_sum and valid becomes keep_valid.
  task automatic send(input bit sel, input logic [7:0] d, input logic [7:0] next_sum,
                      input logic keep_valid, input string tag);
    int f;
    logic [3:0] o;
    f = sel ? 11 : 10;
    o = obs(sel);
    check($sformatf("%s_ready", tag), {3'b000, o[2]}, 4'b0001);
    drive(sel, d, 1'b1);
    @(posedge clk);
    for (int i = 0; i < f * C; i++) begin
      @(negedge clk);
      if (i == 0) drive(sel, next_sum, keep_valid);
      check($sformatf("%s_c%0d", tag, i), obs(sel), {exp_bit(d, sel, i / C), 3'b010});
    end
    @(negedge clk);
    check($sformatf("%s_done", tag), obs(sel), 4'b1101);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d, nxt;
    bit sel, kv;
    int gap;

    // Reset is asserted while valid is high on both instances.
    rst_n = 1'b0;
    drive(1'b0, 8'h5A, 1'b1);
    drive(1'b1, 8'hA5, 1'b1);
    repeat (3) @(negedge clk);
    check("rst_a", obs(1'b0), 4'b1100);
    check("rst_b", obs(1'b1), 4'b1100);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(1'b0, 3, "post_rst_a");
    idle_check(1'b1, 1, "post_rst_b");

    // Directed frames.
    send(1'b0, 8'hA5, 8'h00, 1'b0, "a5");
    idle_check(1'b0, 2, "a5");
    send(1'b1, 8'h07, 8'h00, 1'b0, "p07");
    send(1'b1, 8'h03, 8'h00, 1'b0, "p03");
    idle_check(1'b1, 1, "p03");

    // Back-to-back: valid is held high, and the second frame must start right after the first one's done cycle.
    send(1'b0, 8'h00, 8'hFF, 1'b1, "b2b0");
    send(1'b0, 8'hFF, 8'h00, 1'b0, "b2b1");

    // sum_i changes mid-frame with valid held: 0x3C goes out only after the current frame ends.
    send(1'b0, 8'h5A, 8'h3C, 1'b1, "vb0");
    send(1'b0, 8'h3C, 8'h3C, 1'b0, "vb1");
    send(1'b0, 8'h11, 8'h3C, 1'b0, "vb2");
    idle_check(1'b0, 2 * C, "vb2");

    // Reset in the middle of data bit 3.
    drive(1'b0, 8'hC3, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'hC3, 1'b0);
    repeat (4 * C + 1) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("mid_rst", obs(1'b0), 4'b1100);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(1'b0, 2, "mid_rst");
    send(1'b0, 8'($urandom), 8'h00, 1'b0, "after_rst");

    // Random frames on both instances, with random gaps and random back-to-back pairs.
    sel = 1'b0;
    d = 8'($urandom);
    for (int n = 0; n < 24; n++) begin
      nxt = 8'($urandom);
      kv  = (n == 23) ? 1'b0 : 1'($urandom_range(0, 1));
      send(sel, d, nxt, kv, $sformatf("rnd%0d", n));
      if (!kv) begin
        gap = $urandom_range(0, 3);
        if (gap > 0) idle_check(sel, gap, $sformatf("rnd%0d", n));
        sel = 1'($urandom_range(0, 1));
      end
      d = nxt;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_uart_tx.md
Name: sum_uart_tx

Overview:
Downstream stage of the 8-bit adder. It takes each 8-bit sum through a valid/ready handshake and serialises it as an asynchronous UART frame on a single output pin. The frame is LSB first, with an optional even-parity bit. This lets the adder result leave the chip on one pin rather than eight.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
PARITY_EN, 0, 1 inserts an even-parity bit between the data bits and the stop bit; 0 omits it.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
sum_i  input  8  sum byte from the adder.
sum_valid_i  input  1  sum_i holds a byte to transmit.
sum_ready_o  output  1  block can accept a byte this cycle.
tx_o  output  1  UART line; idle and mark level are high.
busy_o  output  1  a frame is in progress.
done_o  output  1  single-cycle pulse when a frame finishes.

Behaviour:
- Reset (rst_n low): asynchronous, takes effect immediately.
  - tx_o=1, busy_o=0, done_o=0, sum_ready_o=1.
  - State goes to IDLE; bit counter and baud counter clear to 0.
  - Reset during a frame abandons that frame; the line returns high at once.
- Handshake:
  - sum_ready_o = (state==IDLE); no combinational path from sum_valid_i.
  - A transfer occurs on the rising edge where sum_valid_i & sum_ready_o are both high.
  - On a transfer, sum_i is copied into the shift register. Parity is computed as the XOR of the 8 bits.
  - sum_valid_i while sum_ready_o is low is ignored; there is no buffering.
- States and transitions:
  - IDLE: tx_o=1. A transfer moves to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx_o = shreg[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After the 8th bit, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx_o = even-parity bit (XOR of the data) for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles, then IDLE.
- Registered outputs:
  - tx_o is registered.
  - For a transfer at edge k, tx_o falls after edge k.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length: F = 10 bits (11 with parity).
  - The state returns to IDLE at edge k + F·CLKS_PER_BIT.
  - In the cycle following that edge: done_o=1 for exactly one cycle, sum_ready_o=1, busy_o=0.
- busy_o = (state != IDLE), registered.
- Back-to-back frames: a transfer in the first IDLE cycle after done_o starts the next start bit immediately. There is no extra idle gap beyond the stop bit.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is held at 0 in IDLE.
- Bit counter: 3 bits, wraps 7→0 on leaving DATA.
- sum_i is sampled only on the transfer edge. Changes to sum_i mid-frame have no effect.

Decomposition:
- Package sum_uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - DATA_BITS=8;
  - helper function frame_bits(PARITY_EN) returning 10 or 11.
- Sub-module sum_uart_baud_cnt:
  - parameter CLKS_PER_BIT; inputs clk, rst_n, run;
  - output tick, high on the last cycle of each bit period.
  - The FSM advances only on tick.

Test Plan:
- Reset value: rst_n low with sum_valid_i=1 → tx_o=1, sum_ready_o=1, busy_o=0, done_o=0. After release with valid low, all stay at these values.
- 0xA5, CLKS_PER_BIT=4, PARITY_EN=0:
  - tx_o sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - sum_ready_o low for 40 cycles; done_o high for one cycle at capture+40.
- 0x07, PARITY_EN=1: parity bit=1, 11-bit frame (44 cycles at CLKS_PER_BIT=4). For 0x03, parity bit=0.
- Back-to-back 0x00 then 0xFF with sum_valid_i held high:
  - frames are contiguous, the second start bit directly follows the first stop bit;
  - second frame data bits are all 1.
- Valid during busy: change sum_i to 0x3C mid-frame while holding valid → the current frame is unaffected. 0x3C is sent only after done_o, and only if valid is still high.
- Reset mid-frame: assert rst_n during DATA bit 3 → tx_o=1 immediately (asynchronous), busy_o=0. A new transfer after release produces a clean full frame.
